// File: rtl/dsi_pattern_feeder.sv
// Test-pattern pixel source for the DSI core pixel FIFO.
// Frames are started by the core's next-frame/vsync handshake and throttled by almost-full.
module dsi_pattern_feeder #(
  parameter int g_pixels_per_clock = 1,
  parameter int g_dim_bits         = 12
) (
  input  logic                            clk_sys_i,
  input  logic                            rst_i,
  input  logic                            enable_i,
  input  logic [g_dim_bits-1:0]           h_size_i,
  input  logic [g_dim_bits-1:0]           v_size_i,
  input  logic [1:0]                      pattern_i,
  input  logic [23:0]                     solid_rgb_i,
  input  logic                            pix_next_frame_i,
  input  logic                            pix_almost_full_i,
  output logic                            pix_vsync_o,
  output logic [24*g_pixels_per_clock-1:0] pix_o,
  output logic                            pix_wr_o,
  output logic                            busy_o,
  output logic                            cfg_err_o,
  output logic [15:0]                     frame_count_o
);

  localparam int PPC = g_pixels_per_clock;
  localparam int DW  = g_dim_bits;
  localparam logic [DW-1:0] PPC_W = DW'(PPC);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT_NF = 2'd1;
  localparam logic [1:0] S_VSYNC   = 2'd2;
  localparam logic [1:0] S_STREAM  = 2'd3;

  logic [1:0]    state_q;
  logic [DW-1:0] h_q;
  logic [DW-1:0] v_q;
  logic [1:0]    pat_q;
  logic [23:0]   solid_q;
  logic [DW-1:0] thr_q [7];
  logic [DW-1:0] x_q;
  logic [DW-1:0] y_q;

  logic          cfg_bad;
  logic [DW-1:0] step;
  logic          x_end;
  logic          y_end;
  logic [24*PPC-1:0] pix_d;

  assign cfg_bad = (h_size_i == '0) || (v_size_i == '0) ||
                   ((h_size_i % PPC_W) != '0);
  assign step  = h_size_i >> 3;
  assign x_end = (x_q == h_q - PPC_W);
  assign y_end = (y_q == v_q - DW'(1));

  function automatic logic [23:0] bar_rgb(input logic [2:0] i);
    logic [23:0] c;
    c = 24'h000000;
    unique case (i)
      3'd0: c = 24'hFFFFFF;
      3'd1: c = 24'hFFFF00;
      3'd2: c = 24'h00FFFF;
      3'd3: c = 24'h00FF00;
      3'd4: c = 24'hFF00FF;
      3'd5: c = 24'hFF0000;
      3'd6: c = 24'h0000FF;
      3'd7: c = 24'h000000;
    endcase
    return c;
  endfunction

  // One pattern generator per pixel lane; lane k draws column x+k.
  for (genvar k = 0; k < PPC; k++) begin : g_lane
    logic [DW-1:0] px;
    logic [DW-1:0] sum;
    logic [2:0]    bar;
    logic [23:0]   rgb;

    assign px  = x_q + DW'(k);
    assign sum = px + y_q;

    always_comb begin
      bar = '0;
      for (int j = 0; j < 7; j++)
        if (px >= thr_q[j]) bar = bar + 3'd1;
    end

    always_comb begin
      rgb = 24'h000000;
      unique case (1'b1)
        pat_q == 2'd0: rgb = solid_q;
        pat_q == 2'd1: rgb = bar_rgb(bar);
        pat_q == 2'd2: rgb = {px[7:0], y_q[7:0], sum[7:0]};
        pat_q == 2'd3: rgb = (px[3] ^ y_q[3]) ? 24'hFFFFFF : 24'h000000;
      endcase
    end

    assign pix_d[24*k +: 24] = rgb;
  end

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      h_q           <= '0;
      v_q           <= '0;
      pat_q         <= '0;
      solid_q       <= '0;
      x_q           <= '0;
      y_q           <= '0;
      pix_vsync_o   <= 1'b0;
      pix_o         <= '0;
      pix_wr_o      <= 1'b0;
      busy_o        <= 1'b0;
      cfg_err_o     <= 1'b0;
      frame_count_o <= '0;
      for (int j = 0; j < 7; j++) thr_q[j] <= '0;
    end else begin
      pix_wr_o <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (enable_i) state_q <= S_WAIT_NF;
        end
        S_WAIT_NF: begin
          if (!enable_i) begin
            state_q <= S_IDLE;
          end else if (pix_next_frame_i) begin
            h_q       <= h_size_i;
            v_q       <= v_size_i;
            pat_q     <= pattern_i;
            solid_q   <= solid_rgb_i;
            cfg_err_o <= cfg_bad;
            for (int j = 0; j < 7; j++) thr_q[j] <= DW'(j + 1) * step;
            if (!cfg_bad) begin
              state_q     <= S_VSYNC;
              pix_vsync_o <= 1'b1;
              busy_o      <= 1'b1;
            end
          end
        end
        // Level held until the core has seen it in its slower clock.
        S_VSYNC: begin
          if (!pix_next_frame_i) begin
            pix_vsync_o <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            state_q     <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (!pix_almost_full_i) begin
            pix_o    <= pix_d;
            pix_wr_o <= 1'b1;
            if (x_end) begin
              x_q <= '0;
              if (y_end) begin
                y_q           <= '0;
                frame_count_o <= frame_count_o + 16'd1;
                busy_o        <= 1'b0;
                state_q       <= S_WAIT_NF;
              end else begin
                y_q <= y_q + DW'(1);
              end
            end else begin
              x_q <= x_q + PPC_W;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsi_pattern_feeder.sv
// Scoreboard bench for dsi_pattern_feeder: random frames vs a per-pixel reference.
// Two instances cover one and two pixels per clock.
module tb_dsi_pattern_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        en1, nf1, af1;
  logic [11:0] h1, v1;
  logic [1:0]  pat1;
  logic [23:0] sol1;
  logic        vs1, wr1, busy1, err1;
  logic [23:0] pix1;
  logic [15:0] fc1;

  logic        en2, nf2, af2;
  logic [11:0] h2, v2;
  logic [1:0]  pat2;
  logic [23:0] sol2;
  logic        vs2, wr2, busy2, err2;
  logic [47:0] pix2;
  logic [15:0] fc2;

  dsi_pattern_feeder #(.g_pixels_per_clock(1), .g_dim_bits(12)) dut1 (
    .clk_sys_i(clk), .rst_i(rst), .enable_i(en1),
    .h_size_i(h1), .v_size_i(v1), .pattern_i(pat1),
    .solid_rgb_i(sol1), .pix_next_frame_i(nf1),
    .pix_almost_full_i(af1), .pix_vsync_o(vs1), .pix_o(pix1),
    .pix_wr_o(wr1), .busy_o(busy1), .cfg_err_o(err1),
    .frame_count_o(fc1)
  );

  dsi_pattern_feeder #(.g_pixels_per_clock(2), .g_dim_bits(12)) dut2 (
    .clk_sys_i(clk), .rst_i(rst), .enable_i(en2),
    .h_size_i(h2), .v_size_i(v2), .pattern_i(pat2),
    .solid_rgb_i(sol2), .pix_next_frame_i(nf2),
    .pix_almost_full_i(af2), .pix_vsync_o(vs2), .pix_o(pix2),
    .pix_wr_o(wr2), .busy_o(busy2), .cfg_err_o(err2),
    .frame_count_o(fc2)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [23:0] q1[$];
  logic [47:0] q2[$];
  int wr_cnt1 = 0;
  int wr_cnt2 = 0;
  logic af_prev = 1'b0;
  logic [15:0] fc_exp1 = '0;
  logic [15:0] fc_exp2 = '0;

  task automatic chk(input string name, input logic [47:0] act,
                     input logic [47:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] ref_pix(input logic [1:0] pat,
      input logic [23:0] sol, input int h, input int px, input int y);
    int q, idx;
    logic [23:0] c;
    c = 24'h0;
    case (pat)
      2'd0: c = sol;
      2'd1: begin
        q = h / 8;
        idx = (q == 0) ? 7 : px / q;
        if (idx > 7) idx = 7;
        case (idx)
          0: c = 24'hFFFFFF;
          1: c = 24'hFFFF00;
          2: c = 24'h00FFFF;
          3: c = 24'h00FF00;
          4: c = 24'hFF00FF;
          5: c = 24'hFF0000;
          6: c = 24'h0000FF;
          default: c = 24'h000000;
        endcase
      end
      2'd2: c = {8'(px), 8'(y), 8'(px + y)};
      default: c = (((px >> 3) ^ (y >> 3)) & 1) != 0 ? 24'hFFFFFF : 24'h0;
    endcase
    return c;
  endfunction

  always @(negedge clk) begin
    if (wr1) begin
      wr_cnt1++;
      chk("af_gate", 48'(af_prev), 48'd0);
      if (q1.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL dut1_extra_write: got %06h expected none", pix1);
      end else begin
        chk("dut1_pix", 48'(pix1), 48'(q1.pop_front()));
      end
    end
    af_prev = af1;
    if (wr2) begin
      wr_cnt2++;
      if (q2.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL dut2_extra_write: got %012h expected none", pix2);
      end else begin
        chk("dut2_pix", pix2, q2.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame1(input int h, input int v, input logic [1:0] pat,
                        input logic [23:0] sol, input bit rnd_af,
                        input bit drop_en);
    int base;
    bit ok;
    h1 = 12'(h); v1 = 12'(v); pat1 = pat; sol1 = sol; en1 = 1'b1;
    for (int y = 0; y < v; y++)
      for (int x = 0; x < h; x++)
        q1.push_back(ref_pix(pat, sol, h, x, y));
    base = wr_cnt1;
    nf1 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = vs1;
    end
    chk("vsync_rise", 48'(ok), 48'd1);
    repeat (3) tick();
    @(negedge clk);
    chk("vsync_hold", 48'(vs1), 48'd1);
    chk("busy_vsync", 48'(busy1), 48'd1);
    chk("err_clear", 48'(err1), 48'd0);
    chk("no_wr_vsync", 48'(wr_cnt1 - base), 48'd0);
    tick();
    nf1 = 1'b0;
    h1 = 12'($urandom); pat1 = 2'($urandom); sol1 = 24'($urandom);
    if (drop_en) en1 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      tick();
      af1 = rnd_af ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      ok = !busy1;
    end
    chk("frame_done", 48'(ok), 48'd1);
    af1 = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    fc_exp1++;
    chk("wr_count", 48'(wr_cnt1 - base), 48'(h * v));
    chk("frame_count", 48'(fc1), 48'(fc_exp1));
    chk("busy_low", 48'(busy1), 48'd0);
    chk("vsync_low", 48'(vs1), 48'd0);
    chk("q_empty", 48'(q1.size()), 48'd0);
    q1.delete();
  endtask

  initial begin
    int base;
    bit ok;
    rst = 1'b1;
    en1 = 0; nf1 = 0; af1 = 0; h1 = 0; v1 = 0; pat1 = 0; sol1 = 0;
    en2 = 0; nf2 = 0; af2 = 0; h2 = 0; v2 = 0; pat2 = 0; sol2 = 0;
    repeat (3) tick();
    chk("rst_vsync", 48'(vs1), 48'd0);
    chk("rst_wr", 48'(wr1), 48'd0);
    chk("rst_busy", 48'(busy1), 48'd0);
    chk("rst_err", 48'(err1), 48'd0);
    chk("rst_fc", 48'(fc1), 48'd0);
    chk("rst_pix", 48'(pix1), 48'd0);
    rst = 1'b0;
    tick();

    frame1(4, 2, 2'd0, 24'h123456, 1'b0, 1'b0);
    frame1(16, 1, 2'd1, 24'h0, 1'b0, 1'b0);
    frame1(300, 2, 2'd2, 24'h0, 1'b1, 1'b0);
    frame1(24, 3, 2'd3, 24'h0, 1'b1, 1'b0);
    for (int r = 0; r < 4; r++)
      frame1($urandom_range(1, 40), $urandom_range(1, 4),
             2'($urandom), 24'($urandom), 1'b1, 1'b0);

    // Zero width must be rejected without a vsync.
    h1 = 12'd0; v1 = 12'd2; en1 = 1'b1; nf1 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      ok = ok | vs1;
    end
    chk("err_h0", 48'(err1), 48'd1);
    chk("err_no_vsync", 48'(ok), 48'd0);
    nf1 = 1'b0;
    tick();

    en2 = 1'b1; h2 = 12'd5; v2 = 12'd2; pat2 = 2'd2; nf2 = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    chk("err_ppc2", 48'(err2), 48'd1);
    chk("err_ppc2_vs", 48'(vs2), 48'd0);
    nf2 = 1'b0;
    tick();
    h2 = 12'd6;
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 6; x += 2)
        q2.push_back({ref_pix(2'd2, 24'h0, 6, x + 1, y),
                      ref_pix(2'd2, 24'h0, 6, x, y)});
    base = wr_cnt2;
    nf2 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = vs2;
    end
    chk("ppc2_vsync", 48'(ok), 48'd1);
    chk("ppc2_err_clr", 48'(err2), 48'd0);
    tick();
    nf2 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      @(negedge clk);
      ok = !busy2;
    end
    repeat (3) tick();
    @(negedge clk);
    fc_exp2++;
    chk("ppc2_done", 48'(ok), 48'd1);
    chk("ppc2_wr_count", 48'(wr_cnt2 - base), 48'd6);
    chk("ppc2_fc", 48'(fc2), 48'(fc_exp2));
    chk("ppc2_q_empty", 48'(q2.size()), 48'd0);
    q2.delete();

    // Enable dropped mid-frame: frame finishes, then no new vsync.
    frame1(20, 2, 2'd3, 24'h0, 1'b0, 1'b1);
    nf1 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      ok = ok | vs1;
    end
    chk("en_off_no_vsync", 48'(ok), 48'd0);
    nf1 = 1'b0;
    tick();

    // Reset in the middle of a frame.
    en1 = 1'b1; h1 = 12'd100; v1 = 12'd4; pat1 = 2'd0; sol1 = 24'hABCDEF;
    for (int i = 0; i < 400; i++) q1.push_back(24'hABCDEF);
    tick();
    nf1 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = vs1;
    end
    chk("rst_frame_vsync", 48'(ok), 48'd1);
    tick();
    nf1 = 1'b0;
    repeat (20) tick();
    rst = 1'b1;
    #1;
    chk("midrst_wr", 48'(wr1), 48'd0);
    chk("midrst_busy", 48'(busy1), 48'd0);
    chk("midrst_vsync", 48'(vs1), 48'd0);
    chk("midrst_fc", 48'(fc1), 48'd0);
    chk("midrst_pix", 48'(pix1), 48'd0);
    repeat (2) tick();
    rst = 1'b0;
    q1.delete();
    q2.delete();
    fc_exp1 = '0;
    fc_exp2 = '0;
    base = wr_cnt1;
    repeat (30) tick();
    chk("midrst_no_wr", 48'(wr_cnt1 - base), 48'd0);

    frame1(8, 2, 2'd1, 24'h0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dsi_pattern_feeder.md
Name: dsi_pattern_feeder

Overview:
- Upstream pixel source for the DSI core's pixel FIFO interface, in the system clock domain.
- Generates complete frames of a selectable test pattern: solid, colour bars, gradient or checker.
- Frame start is handshaked with the core's next-frame/vsync signals.
- Pixels are written only while the core's FIFO is not almost full.
- Used for panel bring-up and as the default image source when no video input is present.

Parameters:
- g_pixels_per_clock, 1: pixels per output word; must match the DSI core setting.
- g_dim_bits, 12: width of the frame size inputs and of the x/y counters.

Ports:
- clk_sys_i  in  1  system clock; the only clock.
- rst_i  in  1  asynchronous, active-high reset.
- enable_i  in  1  allow new frames to start.
- h_size_i  in  g_dim_bits  active pixels per line.
- v_size_i  in  g_dim_bits  active lines per frame.
- pattern_i  in  2  pattern select: 0 solid, 1 bars, 2 gradient, 3 checker.
- solid_rgb_i  in  24  solid colour, {R,G,B}.
- pix_next_frame_i  in  1  core idle and waiting for a frame (already synchronised to clk_sys_i).
- pix_almost_full_i  in  1  core FIFO almost full.
- pix_vsync_o  out  1  frame start request to the core.
- pix_o  out  24*g_pixels_per_clock  pixel word; pixel k is at [24k+:24], {R[23:16],G[15:8],B[7:0]}.
- pix_wr_o  out  1  FIFO write strobe.
- busy_o  out  1  high from the vsync request until the last pixel of the frame is written.
- cfg_err_o  out  1  latched configuration invalid.
- frame_count_o  out  16  completed frames; wraps modulo 2^16.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, counters 0. Reset is honoured in every state, including mid-frame; no further writes occur after reset.
- IDLE:
  - If enable_i=1, go to WAIT_NF.
  - Otherwise stay.
- WAIT_NF:
  - If enable_i=0, go to IDLE.
  - Else if pix_next_frame_i=1:
    - Latch h_size, v_size, pattern and solid colour.
    - Compute bar thresholds t_j = j*(h_size>>3), j=1..7.
    - Config check: h_size=0, v_size=0, or h_size not a multiple of g_pixels_per_clock sets cfg_err_o=1 and stays in WAIT_NF.
    - Valid config clears cfg_err_o, then go to VSYNC.
- VSYNC:
  - pix_vsync_o=1 and busy_o=1.
  - Hold until pix_next_frame_i=0, then drop vsync and go to STREAM. The level is held because the core resynchronises vsync into a slower clock.
- STREAM:
  - x=0, y=0 on entry.
  - Each cycle with pix_almost_full_i=0: register pix_o for coordinates (x+k, y), k=0..ppc-1, with pix_wr_o=1 on the next cycle (1-cycle latency).
  - Advance x by ppc.
  - At x = h_size-ppc: x←0, y←y+1.
  - If pix_almost_full_i=1, pix_wr_o=0 next cycle and the counters hold. The FIFO's 20-entry slack covers the 1-cycle latency.
  - After writing the last pixel (x=h_size-ppc, y=v_size-1): frame_count_o+1, busy_o←0, return to WAIT_NF.
- Timing rules:
  - enable_i and input changes during STREAM have no effect on the current frame.
  - enable_i is sampled only in IDLE/WAIT_NF.
  - Exactly h_size*v_size/ppc writes occur per frame.
  - pix_wr_o=0 outside STREAM.
- Patterns:
  - 0, solid: every pixel is the latched solid colour.
  - 1, bars: bar index = number of t_j ≤ px, saturating at 7. Colours by index: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - 2, gradient: R=px[7:0], G=y[7:0], B=(px+y)[7:0].
  - 3, checker: px[3]^y[3] ? FFFFFF : 000000.
  - px denotes x+k.
- Arithmetic: all counters are unsigned g_dim_bits wide. A counter never passes h_size-ppc or v_size-1.

Test Plan:
- Solid colour 123456, 4x2 frame, ppc=1, almost_full=0, next_frame pulse:
  - vsync stays high until next_frame drops.
  - Then exactly 8 consecutive writes of 123456.
  - frame_count=1, busy falls after the 8th write.
- Bars, h_size=16, 1 line:
  - Writes FFFFFF,FFFFFF,FFFF00,FFFF00,…,000000,000000, two pixels per bar.
- Gradient, 300x2 frame, with almost_full toggled randomly:
  - No write while almost_full is high, except the single write in flight.
  - Written x sequence wraps 255→0 in R.
  - Line 2 has G=01.
  - 600 writes in total.
- Config errors:
  - h_size=0 → cfg_err_o=1, no vsync.
  - ppc=2 with h_size=5 → cfg_err_o=1.
  - Correcting to h_size=6 on the next next_frame → cfg_err_o=0 and 3 writes per line.
- Control during and around a frame:
  - enable_i dropped mid-frame → the frame completes, then the block returns to IDLE with no new vsync.
  - rst_i asserted mid-STREAM → outputs 0 immediately, no further writes.
  - frame_count wraps FFFF→0000.
